pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Central stall/flush sequencer for the 5-stage pipelined core.
- Detects load-use hazards and taken-branch redirects resolved in EX.
- Freezes the pipeline while the data-memory access in MEM waits on a `dmem_ready` handshake.
- Watchdog latches a sticky error and halts the core if memory never answers.
- Sits beside the main and ALU control units; drives every pipeline-register enable and flush, plus the PC select.

## Interface
Parameters:
- `WAIT_MAX`, 16: MEM_WAIT cycles allowed before the watchdog trips (≥1).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: ID instruction actually reads that source.
- `ex_rd` in 5: destination of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_branch`, `ex_zero` in 1 each: branch in EX, and the ALU zero flag.
- `mem_access` in 1: MEM instruction is a load or store.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we` out 1 each: register enables.
- `ifid_flush`, `idex_flush`, `memwb_bubble` out 1 each: insert NOP.
- `pc_src` out 1: select the branch target.
- `dmem_req` out 1: data-memory request.
- `mem_err` out 1: sticky watchdog error.
- `stall_cycles`, `flush_count` out CNT_W each: performance counters.

## Operation
States: RUN, MEM_WAIT, ERR. Reset enters RUN, clears the watchdog counter, the perf counters and `mem_err`.

While `rst_n`=0, all outputs are 0.

Default in RUN: all `*_we`=1, all flushes/bubbles=0, `pc_src`=0.

Priority, highest first: ERR, memory stall, branch, load-use.

Memory stall:
- `dmem_req` = `mem_access` in RUN, and 1 in MEM_WAIT.
- RUN with `mem_access`=1 and `dmem_ready`=0:
  - go to MEM_WAIT;
  - `pc_we`/`ifid_we`/`idex_we`/`exmem_we`=0, `memwb_bubble`=1;
  - `pc_src`=0, no flushes.
- MEM_WAIT with `dmem_ready`=0: hold the same freeze and increment the watchdog.
- MEM_WAIT with `dmem_ready`=1:
  - go to RUN, clear the watchdog;
  - this cycle is evaluated exactly like RUN (branch and load-use rules apply);
  - `memwb_bubble`=0.
- Watchdog reaching `WAIT_MAX` with no ready: go to ERR.

Branch, taken when `ex_branch & ex_zero` and not frozen:
- `pc_src`=1, `ifid_flush`=1, `idex_flush`=1; all enables remain 1.
- Load-use is ignored this cycle, because the ID instruction is squashed.

Load-use, when `ex_mem_read`, `ex_rd`≠0, and (`id_use_rs1` & `id_rs1`==`ex_rd` | `id_use_rs2` & `id_rs2`==`ex_rd`), not frozen, no branch:
- `pc_we`=0, `ifid_we`=0, `idex_flush`=1.
- Hazard clears on the next cycle because the load has moved to MEM.

ERR:
- All enables, flushes, bubbles, `pc_src` and `dmem_req` = 0.
- `mem_err`=1.
- Only `rst_n` exits ERR.

Register x0 never causes a hazard.

## Timing
- Hazard outputs are combinational from the state and current inputs. There is no added latency; the decision applies at the next edge.
- A zero-wait access (`dmem_ready`=1 in the same cycle as `mem_access`) causes no stall.
- Stall length is the number of cycles `dmem_ready` is late.
- Watchdog: the ERR transition happens on the edge ending MEM_WAIT cycle `WAIT_MAX`. `mem_err` is high from the next cycle.
- Asserting `rst_n` mid-stall drops to RUN immediately and deasserts `dmem_req`.
- `dmem_req` must remain high and stable in MEM_WAIT until `dmem_ready`.

## Configuration
`HAZARD_PERF_EN`:
- Defined:
  - `stall_cycles` increments every cycle with `pc_we`=0 outside ERR.
  - `flush_count` increments every cycle with `idex_flush`=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → one cycle of `pc_we`=0, `ifid_we`=0, `idex_flush`=1, then RUN defaults; the same pattern with `ex_rd`=0 → no stall.
- Taken branch: `ex_branch`=1, `ex_zero`=1 → `pc_src`=1, `ifid_flush`=1, `idex_flush`=1 for exactly one cycle. With a load-use pattern present at the same time, only the branch response appears.
- Memory wait: `mem_access`=1, `dmem_ready` late by 3 cycles → 3 frozen cycles with `dmem_req`=1 and `memwb_bubble`=1, then release. A pending taken branch is honored in the release cycle.
- Watchdog: `WAIT_MAX`=4, `dmem_ready` held low → ERR after 4 wait cycles; `mem_err`=1 and all outputs 0 until `rst_n` pulse.
- Reset mid-MEM_WAIT: pulse `rst_n` low → `dmem_req`=0 immediately; RUN after release with `mem_err`=0.
- `HAZARD_PERF_EN` defined: 3-cycle memory stall plus one load-use plus one branch → `stall_cycles`=4, `flush_count`=2. Undefined: both read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipelined core.
//             Resolves, in priority order: watchdog error, data-memory wait,
//             taken branch in EX, load-use hazard between EX and ID.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WAIT_MAX  MEM_WAIT cycles tolerated before the watchdog trips (>= 1)
//    CNT_W     width of the performance counters
//  Ports
//    clk, rst_n                  clock, asynchronous active-low reset
//    id_rs1/id_rs2, id_use_rs*   ID-stage source registers and their use flags
//    ex_rd, ex_mem_read          EX-stage destination and load flag
//    ex_branch, ex_zero          EX-stage branch and ALU zero flag
//    mem_access, dmem_ready      MEM-stage access flag and memory handshake
//    pc_we..exmem_we             pipeline-register enables
//    ifid_flush, idex_flush      flush (NOP insert) controls
//    memwb_bubble                bubble into MEM/WB while memory is waiting
//    pc_src                      select branch target
//    dmem_req                    data-memory request
//    mem_err                     sticky watchdog error
//    stall_cycles, flush_count   performance counters
//  Configuration
//    HAZARD_PERF_EN  defined   : saturating stall/flush counters are built
//                    undefined : counter ports are tied to zero
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             pc_src,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WD_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic w_pc_we, w_ifid_we, w_idex_we, w_exmem_we;
    logic w_ifid_flush, w_idex_flush, w_memwb_bubble, w_pc_src;
    logic w_dmem_req, w_mem_err;
    logic w_frozen, w_branch, w_load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_branch   = ex_branch & ex_zero;

    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        w_pc_we        = 1'b0;
        w_ifid_we      = 1'b0;
        w_idex_we      = 1'b0;
        w_exmem_we     = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_memwb_bubble = 1'b0;
        w_pc_src       = 1'b0;
        w_dmem_req     = 1'b0;
        w_mem_err      = 1'b0;
        w_frozen       = 1'b0;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                // Request stays asserted for the whole wait, independent of
                // mem_access, so it is stable until the handshake completes.
                w_dmem_req = (state_q == ST_WAIT) | mem_access;
                w_frozen   = ~dmem_ready & ((state_q == ST_WAIT) | mem_access);

                if (w_frozen) begin
                    w_memwb_bubble = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_WAIT;
                        wd_d    = '0;
                    end else if (wd_q == c_WD_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end else begin
                    // Release cycle out of MEM_WAIT behaves exactly like RUN.
                    state_d    = ST_RUN;
                    wd_d       = '0;
                    w_pc_we    = 1'b1;
                    w_ifid_we  = 1'b1;
                    w_idex_we  = 1'b1;
                    w_exmem_we = 1'b1;
                    if (w_branch) begin
                        // ID is squashed, so any load-use match is irrelevant.
                        w_pc_src     = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_we      = 1'b0;
                        w_ifid_we    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                // ERR (and the unused encoding) halt the core until reset.
                state_d   = ST_ERR;
                w_mem_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs are forced low while reset is held, even though the state
    // register already sits in RUN.
    assign pc_we        = rst_n & w_pc_we;
    assign ifid_we      = rst_n & w_ifid_we;
    assign idex_we      = rst_n & w_idex_we;
    assign exmem_we     = rst_n & w_exmem_we;
    assign ifid_flush   = rst_n & w_ifid_flush;
    assign idex_flush   = rst_n & w_idex_flush;
    assign memwb_bubble = rst_n & w_memwb_bubble;
    assign pc_src       = rst_n & w_pc_src;
    assign dmem_req     = rst_n & w_dmem_req;
    assign mem_err      = rst_n & w_mem_err;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!w_pc_we && (state_q != ST_ERR) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (w_idex_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed plus randomized bench for pipeline_hazard_ctrl against
//             a cycle-level behavioural model of the hazard rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read;
    logic             ex_branch, ex_zero, mem_access, dmem_ready;
    logic             pc_we, ifid_we, idex_we, exmem_we;
    logic             ifid_flush, idex_flush, memwb_bubble, pc_src;
    logic             dmem_req, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_branch   (ex_branch),
        .ex_zero     (ex_zero),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idex_we     (idex_we),
        .exmem_we    (exmem_we),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_bubble(memwb_bubble),
        .pc_src      (pc_src),
        .dmem_req    (dmem_req),
        .mem_err     (mem_err),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = running, 1 = waiting on memory, 2 = halted by watchdog.
    int m_mode  = 0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;
`ifdef HAZARD_PERF_EN
    bit perf_en = 1'b1;
`else
    bit perf_en = 1'b0;
`endif

    // Packed order: pc_we ifid_we idex_we exmem_we ifid_flush idex_flush
    //               memwb_bubble pc_src dmem_req mem_err
    function automatic logic [9:0] model_ctl();
        logic frozen, hazard;
        if (!rst_n)      return 10'b0;
        if (m_mode == 2) return 10'b0000000001;
        frozen = !dmem_ready && (m_mode == 1 || mem_access);
        hazard = ex_mem_read && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (frozen)                 return 10'b0000_001_0_1_0;
        if (ex_branch && ex_zero)   return {4'b1111, 3'b110, 1'b1, (m_mode == 1) | mem_access, 1'b0};
        if (hazard)                 return {4'b0011, 3'b010, 1'b0, (m_mode == 1) | mem_access, 1'b0};
        return {4'b1111, 3'b000, 1'b0, (m_mode == 1) | mem_access, 1'b0};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check_now(input string tag);
        logic [9:0] obs, exp;
        obs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               memwb_bubble, pc_src, dmem_req, mem_err};
        exp = model_ctl();
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
        end
        n_vec++;
        assert (stall_cycles === CNT_W'(perf_en ? m_stall : 0)) else begin
            n_err++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, perf_en ? m_stall : 0);
        end
        n_vec++;
        assert (flush_count === CNT_W'(perf_en ? m_flush : 0)) else begin
            n_err++;
            $error("FAIL %s flush_count observed=%0d expected=%0d", tag, flush_count, perf_en ? m_flush : 0);
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic cycle(input string tag);
        logic [9:0] e;
        logic frozen;
        #2;
        check_now(tag);
        e = model_ctl();
        frozen = !dmem_ready && (m_mode == 1 || mem_access);
        @(posedge clk);
        if (rst_n && m_mode != 2) begin
            if (e[9] == 1'b0 && m_stall < CNT_MAX) m_stall++;
            if (e[4] == 1'b1 && m_flush < CNT_MAX) m_flush++;
            if (frozen) begin
                if (m_mode == 0) begin
                    m_mode = 1; m_waits = 0;
                end else begin
                    m_waits++;
                    if (m_waits == WAIT_MAX) m_mode = 2;
                end
            end else begin
                m_mode = 0;
            end
        end
        #1;
    endtask

    // Mid-cycle reset pulse: outputs must drop at once, then release.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle("idle");

        // lw x5 in EX, add x6,x5,x1 in ID
        set_lu(5'd5);
        cycle("loaduse");
        clr_in();
        cycle("loaduse_after");
        set_lu(5'd0); id_rs1 = 5'd0;
        cycle("loaduse_x0");
        clr_in();

        // Taken branch with a load-use pattern present at the same time
        set_lu(5'd5); ex_branch = 1'b1; ex_zero = 1'b1;
        cycle("branch_lu");
        clr_in();
        cycle("branch_after");
        ex_branch = 1'b1; ex_zero = 1'b0;
        cycle("branch_not_taken");
        clr_in();

        // Zero-wait access, then memory 3 cycles late with branch at release
        mem_access = 1'b1; dmem_ready = 1'b1;
        cycle("mem_zero_wait");
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        dmem_ready = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
        cycle("mem_release_branch");
        clr_in();
        cycle("mem_after");

        // Watchdog: memory never answers
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < WAIT_MAX + 1; i++) cycle("wdog_wait");
        clr_in();
        for (int i = 0; i < 3; i++) cycle("err_hold");
        pulse_reset("err_reset");
        cycle("err_cleared");

        // Reset in the middle of a wait
        mem_access = 1'b1; dmem_ready = 1'b0;
        cycle("pre_rst_wait0");
        cycle("pre_rst_wait1");
        pulse_reset("mid_wait_reset");
        clr_in();
        cycle("post_rst_run");

        // Randomized traffic biased toward register collisions
        for (int n = 0; n < 800; n++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_branch   = ($urandom_range(0, 3) == 0);
            ex_zero     = 1'($urandom_range(0, 1));
            mem_access  = 1'($urandom_range(0, 1));
            dmem_ready  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
            else                            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
